// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the SDRAM controller port between the camera write stream and the VGA read stream.
// Optional macro RD_PRIORITY_EN: read always wins when both streams are eligible.
module sdram_frame_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int FRAME_WORDS = 76800,
  parameter int BURST_LEN   = 256,
  parameter int USEDW_W     = 10,
  parameter int RD_LOW      = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          wr_bank,
  input  logic [1:0]          rd_bank,
  input  logic                wr_load,
  input  logic                rd_load,
  input  logic [USEDW_W-1:0]  wr_usedw,
  input  logic [USEDW_W-1:0]  rd_usedw,
  output logic                sd_wr_req,
  output logic                sd_rd_req,
  output logic [ADDR_W+1:0]   sd_addr,
  input  logic                sd_ack,
  input  logic                sd_done,
  output logic                frame_write_done,
  output logic                frame_read_done
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

  localparam logic [ADDR_W-1:0]  BURST_A = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]  FRAME_A = ADDR_W'(FRAME_WORDS);
  localparam logic [USEDW_W-1:0] BURST_U = USEDW_W'(BURST_LEN);
  localparam logic [USEDW_W-1:0] RD_LOW_U = USEDW_W'(RD_LOW);

  // Handshake: sd_x_req is a registered level held with sd_addr stable until the
  // cycle sd_ack is sampled high; sd_done ends the burst. Acks/dones outside the
  // matching state are ignored.
  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_addr, rd_addr, wr_addr_inc, rd_addr_inc;
  logic              last_grant_rd;
  logic              wr_load_pend, rd_load_pend;
  logic              wr_elig, rd_elig, grant_wr, grant_rd, wr_fin, rd_fin;

  assign wr_elig     = (wr_usedw >= BURST_U) && !frame_write_done;
  assign rd_elig     = (rd_usedw < RD_LOW_U) && !frame_read_done;
  assign sd_wr_req   = (state == WR_REQ);
  assign sd_rd_req   = (state == RD_REQ);
  assign wr_fin      = (state == WR_BUSY) && sd_done;
  assign rd_fin      = (state == RD_BUSY) && sd_done;
  assign wr_addr_inc = wr_addr + BURST_A;
  assign rd_addr_inc = rd_addr + BURST_A;

  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_elig && rd_elig) begin
`ifdef RD_PRIORITY_EN
          grant_rd = 1'b1;
`else
          grant_wr = last_grant_rd;
          grant_rd = !last_grant_rd;
`endif
        end else begin
          grant_wr = wr_elig;
          grant_rd = rd_elig;
        end
        if (grant_wr)      state_next = WR_REQ;
        else if (grant_rd) state_next = RD_REQ;
      end
      WR_REQ:  if (sd_ack)  state_next = WR_BUSY;
      WR_BUSY: if (sd_done) state_next = IDLE;
      RD_REQ:  if (sd_ack)  state_next = RD_BUSY;
      RD_BUSY: if (sd_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A load during the stream's own burst waits for sd_done and then wins over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr          <= '0;
      frame_write_done <= 1'b1;
      wr_load_pend     <= 1'b0;
    end else if (state == WR_BUSY) begin
      if (sd_done) begin
        wr_load_pend <= 1'b0;
        if (wr_load || wr_load_pend) begin
          wr_addr          <= '0;
          frame_write_done <= 1'b0;
        end else if (wr_addr_inc == FRAME_A) begin
          wr_addr          <= '0;
          frame_write_done <= 1'b1;
        end else begin
          wr_addr <= wr_addr_inc;
        end
      end else if (wr_load) begin
        wr_load_pend <= 1'b1;
      end
    end else if (wr_load) begin
      wr_addr          <= '0;
      frame_write_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr         <= '0;
      frame_read_done <= 1'b1;
      rd_load_pend    <= 1'b0;
    end else if (state == RD_BUSY) begin
      if (sd_done) begin
        rd_load_pend <= 1'b0;
        if (rd_load || rd_load_pend) begin
          rd_addr         <= '0;
          frame_read_done <= 1'b0;
        end else if (rd_addr_inc == FRAME_A) begin
          rd_addr         <= '0;
          frame_read_done <= 1'b1;
        end else begin
          rd_addr <= rd_addr_inc;
        end
      end else if (rd_load) begin
        rd_load_pend <= 1'b1;
      end
    end else if (rd_load) begin
      rd_addr         <= '0;
      frame_read_done <= 1'b0;
    end
  end

  // Bank is captured at grant so bank-switch activity mid-burst cannot disturb sd_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_addr       <= '0;
      last_grant_rd <= 1'b1;
    end else begin
      if (grant_wr)      sd_addr <= {wr_bank, wr_addr};
      else if (grant_rd) sd_addr <= {rd_bank, rd_addr};
      if (wr_fin)        last_grant_rd <= 1'b0;
      else if (rd_fin)   last_grant_rd <= 1'b1;
    end
  end

endmodule
